// File: rtl/slow_clk_gen.sv
// slow_clk_gen: divides the fast clock into a slow clock, sequences the
// downstream stage's reset (held for a fixed number of slow cycles, released
// on a slow falling edge) and keeps saturating fast/slow cycle counters.
module slow_clk_gen #(
    parameter int unsigned DIV      = 4,
    parameter int unsigned RST_HOLD = 3,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             run,
    output logic             slow_clk,
    output logic             slow_reset_l,
    output logic             slow_rise,
    output logic [CNT_W-1:0] slow_count,
    output logic [CNT_W-1:0] fast_count
);

    // Phase counter width and the two phase values that matter: the last
    // phase (where the slow clock is low and a new period may begin) and the
    // first low phase (the slow falling edge).
    localparam int unsigned P_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [P_W-1:0] P_LAST = P_W'(DIV - 1);
    localparam logic [P_W-1:0] P_HALF = P_W'(DIV / 2);

    // Rise counter only needs to reach RST_HOLD, where it sticks.
    localparam int unsigned R_W = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;
    localparam logic [R_W-1:0] RISE_DONE = R_W'(RST_HOLD);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    if (DIV < 2) begin : g_bad_div
        $error("slow_clk_gen: DIV must be at least 2");
    end
    if (RST_HOLD < 1) begin : g_bad_hold
        $error("slow_clk_gen: RST_HOLD must be at least 1");
    end

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StRun,
        StDrain
    } state_t;

    state_t           state_q, state_d;
    logic [P_W-1:0]   p_q, p_d;
    logic [P_W-1:0]   p_next;
    logic             slow_clk_q, slow_clk_d;
    logic             slow_reset_l_q, slow_reset_l_d;
    logic             slow_rise_q, slow_rise_d;
    logic [CNT_W-1:0] slow_count_q, slow_count_d;
    logic [CNT_W-1:0] fast_count_q, fast_count_d;
    logic [R_W-1:0]   rise_cnt_q, rise_cnt_d;
    // Set when DRAIN was entered from RUN, so counters keep running there.
    logic             drain_cnt_q, drain_cnt_d;

    logic             advance;
    logic             clear;
    logic             count_en;

    // Wrap-around successor of the phase counter.
    always_comb begin
        p_next = (p_q == P_LAST) ? '0 : p_q + P_W'(1);
    end

    // FSM next-state: decides when the phase advances, when counters clear or
    // count, and when the downstream reset is released or reasserted.
    always_comb begin
        state_d        = state_q;
        slow_reset_l_d = slow_reset_l_q;
        drain_cnt_d    = drain_cnt_q;
        advance        = 1'b0;
        clear          = 1'b0;
        count_en       = 1'b0;
        unique case (state_q)
            StIdle: begin
                slow_reset_l_d = 1'b0;
                if (run) begin
                    state_d = StHold;
                    clear   = 1'b1;
                end
            end
            StHold: begin
                advance        = 1'b1;
                slow_reset_l_d = 1'b0;
                if (!run) begin
                    state_d     = StDrain;
                    drain_cnt_d = 1'b0;
                end else if (rise_cnt_q == RISE_DONE && p_next == P_HALF) begin
                    // Release on the slow falling edge after enough rises.
                    state_d        = StRun;
                    slow_reset_l_d = 1'b1;
                end
            end
            StRun: begin
                advance  = 1'b1;
                count_en = 1'b1;
                if (!run) begin
                    state_d     = StDrain;
                    drain_cnt_d = 1'b1;
                end
            end
            StDrain: begin
                count_en = drain_cnt_q;
                if (p_q == P_LAST) begin
                    // Period already complete: stop without starting another.
                    state_d        = StIdle;
                    slow_reset_l_d = 1'b0;
                end else begin
                    advance = 1'b1;
                    if (p_next == P_LAST) begin
                        state_d        = StIdle;
                        slow_reset_l_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d        = StIdle;
                slow_reset_l_d = 1'b0;
            end
        endcase
    end

    // Phase and slow clock: parked at the last (low) phase when not
    // advancing, so the first advance always produces a clean rising edge.
    always_comb begin
        p_d         = P_LAST;
        slow_clk_d  = 1'b0;
        slow_rise_d = 1'b0;
        if (advance) begin
            p_d         = p_next;
            slow_clk_d  = (p_next < P_HALF);
            slow_rise_d = (p_q == P_LAST);
        end
    end

    // Saturating counters plus the rise counter that gates reset release.
    always_comb begin
        fast_count_d = fast_count_q;
        slow_count_d = slow_count_q;
        rise_cnt_d   = rise_cnt_q;
        if (clear) begin
            fast_count_d = '0;
            slow_count_d = '0;
            rise_cnt_d   = '0;
        end else begin
            if (count_en && fast_count_q != CNT_MAX) begin
                fast_count_d = fast_count_q + CNT_W'(1);
            end
            if (count_en && slow_rise_d && slow_count_q != CNT_MAX) begin
                slow_count_d = slow_count_q + CNT_W'(1);
            end
            if (state_q == StHold && slow_rise_d && rise_cnt_q != RISE_DONE) begin
                rise_cnt_d = rise_cnt_q + R_W'(1);
            end
        end
    end

    // State register; reset drops the slow clock and downstream reset at once.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q        <= StIdle;
            p_q            <= P_LAST;
            slow_clk_q     <= 1'b0;
            slow_reset_l_q <= 1'b0;
            slow_rise_q    <= 1'b0;
            slow_count_q   <= '0;
            fast_count_q   <= '0;
            rise_cnt_q     <= '0;
            drain_cnt_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            p_q            <= p_d;
            slow_clk_q     <= slow_clk_d;
            slow_reset_l_q <= slow_reset_l_d;
            slow_rise_q    <= slow_rise_d;
            slow_count_q   <= slow_count_d;
            fast_count_q   <= fast_count_d;
            rise_cnt_q     <= rise_cnt_d;
            drain_cnt_q    <= drain_cnt_d;
        end
    end

    assign slow_clk     = slow_clk_q;
    assign slow_reset_l = slow_reset_l_q;
    assign slow_rise    = slow_rise_q;
    assign slow_count   = slow_count_q;
    assign fast_count   = fast_count_q;

endmodule

// File: tb/tb_slow_clk_gen.sv
// Bench for slow_clk_gen: a DIV=4/RST_HOLD=3 instance and a DIV=3/RST_HOLD=1
// instance with 4-bit counters. Expected values are queued per edge number
// and checked by a separate monitor on the falling clock edge.
module tb_slow_clk_gen;

    localparam int S_CLK  = 0;
    localparam int S_RST  = 1;
    localparam int S_RISE = 2;
    localparam int S_SCNT = 3;
    localparam int S_FCNT = 4;
    localparam int O_CLK  = 5;
    localparam int O_RST  = 6;
    localparam int O_SCNT = 7;
    localparam int O_FCNT = 8;

    logic        clk     = 1'b0;
    logic        reset_l = 1'b1;
    logic        run     = 1'b0;
    logic        run2    = 1'b0;

    logic        m_slow_clk, m_slow_reset_l, m_slow_rise;
    logic [31:0] m_slow_count, m_fast_count;
    logic        o_slow_clk, o_slow_reset_l, o_slow_rise;
    logic [3:0]  o_slow_count, o_fast_count;

    slow_clk_gen #(.DIV(4), .RST_HOLD(3), .CNT_W(32)) u_dut (
        .clk          (clk),
        .reset_l      (reset_l),
        .run          (run),
        .slow_clk     (m_slow_clk),
        .slow_reset_l (m_slow_reset_l),
        .slow_rise    (m_slow_rise),
        .slow_count   (m_slow_count),
        .fast_count   (m_fast_count)
    );

    slow_clk_gen #(.DIV(3), .RST_HOLD(1), .CNT_W(4)) u_odd (
        .clk          (clk),
        .reset_l      (reset_l),
        .run          (run2),
        .slow_clk     (o_slow_clk),
        .slow_reset_l (o_slow_reset_l),
        .slow_rise    (o_slow_rise),
        .slow_count   (o_slow_count),
        .fast_count   (o_fast_count)
    );

    always #5 clk = ~clk;

    // Edge number: after rising edge k, cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          tag;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] act_of(input int sel);
        case (sel)
            S_CLK:   act_of = {31'd0, m_slow_clk};
            S_RST:   act_of = {31'd0, m_slow_reset_l};
            S_RISE:  act_of = {31'd0, m_slow_rise};
            S_SCNT:  act_of = m_slow_count;
            S_FCNT:  act_of = m_fast_count;
            O_CLK:   act_of = {31'd0, o_slow_clk};
            O_RST:   act_of = {31'd0, o_slow_reset_l};
            O_SCNT:  act_of = {28'd0, o_slow_count};
            O_FCNT:  act_of = {28'd0, o_fast_count};
            default: act_of = 32'hdead_beef;
        endcase
    endfunction

    task automatic expect_at(input int tag, input int sel, input logic [31:0] v, input string name);
        exp_t e;
        e.tag  = tag;
        e.sel  = sel;
        e.exp  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drain_sb();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: compare every queued expectation due at this edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].tag <= cyc) begin
                e = sb.pop_front();
                if (e.tag != cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s: sampled at E%0d, required at E%0d", e.name, cyc, e.tag);
                end else begin
                    check(e.name, act_of(e.sel), e.exp);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        int base, e0, es, o0, h0, r0;
        int unsigned st_clk[4]  = '{1, 1, 0, 0};
        int unsigned st_rise[4] = '{1, 0, 0, 0};
        int unsigned st_rst[4]  = '{1, 1, 1, 0};
        int unsigned st_fcnt[4] = '{18, 19, 20, 21};

        // Asynchronous reset between edges.
        #2 reset_l = 1'b0;
        #1;
        check("por_slow_clk", {31'd0, m_slow_clk}, 32'd0);
        check("por_slow_reset_l", {31'd0, m_slow_reset_l}, 32'd0);
        check("por_slow_rise", {31'd0, m_slow_rise}, 32'd0);
        check("por_slow_count", m_slow_count, 32'd0);
        check("por_fast_count", m_fast_count, 32'd0);
        check("por_odd_fast_count", {28'd0, o_fast_count}, 32'd0);
        repeat (3) @(negedge clk);
        reset_l = 1'b1;
        base = cyc;

        // Idle with run=0: no slow clock for 20 cycles.
        for (int n = 1; n <= 20; n++) begin
            expect_at(base + n, S_CLK, 32'd0, $sformatf("idle_clk n=%0d", n));
            expect_at(base + n, S_RST, 32'd0, $sformatf("idle_rst n=%0d", n));
        end
        wait_cyc(base + 20);

        // Start and count: run sampled at E0.
        run = 1'b1;
        e0 = cyc + 1;
        for (int n = 0; n <= 28; n++) begin
            expect_at(e0 + n, S_CLK, 32'(n >= 1 && (n - 1) % 4 < 2), $sformatf("start_clk n=%0d", n));
            expect_at(e0 + n, S_RISE, 32'(n >= 1 && (n - 1) % 4 == 0), $sformatf("start_rise n=%0d", n));
            expect_at(e0 + n, S_RST, 32'(n >= 11), $sformatf("start_rst n=%0d", n));
            expect_at(e0 + n, S_SCNT, 32'((n < 13) ? 0 : (n - 13) / 4 + 1), $sformatf("start_scnt n=%0d", n));
            expect_at(e0 + n, S_FCNT, 32'((n < 12) ? 0 : n - 11), $sformatf("start_fcnt n=%0d", n));
        end
        wait_cyc(e0 + 28);

        // Stop mid-high: run=0 sampled on the edge that makes p=0.
        run = 1'b0;
        es = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            expect_at(es + k, S_CLK, 32'(st_clk[k]), $sformatf("stop_clk k=%0d", k));
            expect_at(es + k, S_RISE, 32'(st_rise[k]), $sformatf("stop_rise k=%0d", k));
            expect_at(es + k, S_RST, 32'(st_rst[k]), $sformatf("stop_rst k=%0d", k));
            expect_at(es + k, S_SCNT, 32'd5, $sformatf("stop_scnt k=%0d", k));
            expect_at(es + k, S_FCNT, 32'(st_fcnt[k]), $sformatf("stop_fcnt k=%0d", k));
        end
        for (int k = 4; k <= 10; k++) begin
            expect_at(es + k, S_CLK, 32'd0, $sformatf("stopped_clk k=%0d", k));
            expect_at(es + k, S_RST, 32'd0, $sformatf("stopped_rst k=%0d", k));
            expect_at(es + k, S_SCNT, 32'd5, $sformatf("stopped_scnt k=%0d", k));
            expect_at(es + k, S_FCNT, 32'd21, $sformatf("stopped_fcnt k=%0d", k));
        end
        // Pulse run while draining; it must be ignored.
        wait_cyc(es + 1);
        run = 1'b1;
        wait_cyc(es + 2);
        run = 1'b0;
        wait_cyc(es + 10);
        drain_sb();

        // Odd divide with 4-bit saturating counters.
        run2 = 1'b1;
        o0 = cyc + 1;
        for (int n = 0; n <= 24; n++) begin
            expect_at(o0 + n, O_CLK, 32'(n >= 1 && (n - 1) % 3 == 0), $sformatf("odd_clk n=%0d", n));
            expect_at(o0 + n, O_RST, 32'(n >= 2), $sformatf("odd_rst n=%0d", n));
            expect_at(o0 + n, O_SCNT, 32'((n < 4) ? 0 : (n - 4) / 3 + 1), $sformatf("odd_scnt n=%0d", n));
            expect_at(o0 + n, O_FCNT, 32'((n < 3) ? 0 : ((n - 2 > 15) ? 15 : n - 2)),
                      $sformatf("odd_fcnt n=%0d", n));
        end
        wait_cyc(o0 + 24);
        drain_sb();

        // Restart main instance: counters cleared on HOLD entry; then reset mid-HOLD.
        run = 1'b1;
        h0 = cyc + 1;
        expect_at(h0, S_SCNT, 32'd0, "hold_clear_scnt");
        expect_at(h0, S_FCNT, 32'd0, "hold_clear_fcnt");
        expect_at(h0, S_CLK, 32'd0, "hold_clk n=0");
        expect_at(h0 + 1, S_CLK, 32'd1, "hold_clk n=1");
        expect_at(h0 + 1, S_RISE, 32'd1, "hold_rise n=1");
        expect_at(h0 + 2, S_CLK, 32'd1, "hold_clk n=2");
        expect_at(h0 + 2, S_RST, 32'd0, "hold_rst n=2");
        wait_cyc(h0 + 2);
        drain_sb();
        #2;
        run2    = 1'b0;
        reset_l = 1'b0;
        #1;
        check("midhold_slow_clk", {31'd0, m_slow_clk}, 32'd0);
        check("midhold_slow_reset_l", {31'd0, m_slow_reset_l}, 32'd0);
        check("midhold_slow_rise", {31'd0, m_slow_rise}, 32'd0);
        check("midhold_odd_slow_reset_l", {31'd0, o_slow_reset_l}, 32'd0);
        check("midhold_odd_fast_count", {28'd0, o_fast_count}, 32'd0);
        run = 1'b0;
        repeat (2) @(negedge clk);
        reset_l = 1'b1;
        base = cyc;
        for (int n = 1; n <= 4; n++) begin
            expect_at(base + n, S_CLK, 32'd0, $sformatf("postrst_clk n=%0d", n));
        end
        wait_cyc(base + 4);

        // Restart after reset: same start sequence, counters from 0.
        run = 1'b1;
        r0 = cyc + 1;
        for (int n = 0; n <= 14; n++) begin
            expect_at(r0 + n, S_CLK, 32'(n >= 1 && (n - 1) % 4 < 2), $sformatf("restart_clk n=%0d", n));
            expect_at(r0 + n, S_RST, 32'(n >= 11), $sformatf("restart_rst n=%0d", n));
            expect_at(r0 + n, S_SCNT, 32'((n < 13) ? 0 : (n - 13) / 4 + 1), $sformatf("restart_scnt n=%0d", n));
            expect_at(r0 + n, S_FCNT, 32'((n < 12) ? 0 : n - 11), $sformatf("restart_fcnt n=%0d", n));
        end
        wait_cyc(r0 + 14);
        drain_sb();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exhausted, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
